// File: rtl/dmem_store_buffer.sv
// Posted-write store buffer between the core data port and single-port data memory.
// Optional build macro: STORE_FWD_EN (load data forwarding from pending stores).
module dmem_store_buffer #(
  parameter int P_DATA_WIDTH      = 32,
  parameter int P_DMEM_ADDR_WIDTH = 11,
  parameter int P_DEPTH           = 4
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_core_we,
  input  logic                         i_core_re,
  input  logic [P_DMEM_ADDR_WIDTH-1:0] i_core_addr,
  input  logic [P_DATA_WIDTH-1:0]      i_core_wdata,
  output logic [P_DATA_WIDTH-1:0]      o_core_rdata,
  output logic                         o_core_stall,
  output logic                         o_mem_we,
  output logic [P_DMEM_ADDR_WIDTH-1:0] o_mem_addr,
  output logic [P_DATA_WIDTH-1:0]      o_mem_wdata,
  input  logic [P_DATA_WIDTH-1:0]      i_mem_rdata,
  output logic                         o_empty
);

  localparam int PW = $clog2(P_DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0]                head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]                count_q, count_d;
  logic [P_DMEM_ADDR_WIDTH-1:0] addr_q [P_DEPTH];
  logic [P_DMEM_ADDR_WIDTH-1:0] addr_d [P_DEPTH];
  logic [P_DATA_WIDTH-1:0]      data_q [P_DEPTH];
  logic [P_DATA_WIDTH-1:0]      data_d [P_DEPTH];

  logic                    is_store, is_load, nonempty, hit, drain, push;
  logic [PW-1:0]           slot;
  logic [P_DATA_WIDTH-1:0] fwd_data;

  assign is_store = i_core_we;
  assign is_load  = i_core_re & ~i_core_we;
  assign nonempty = (count_q != '0);

  // Walk oldest to youngest so the last match (closest to tail) wins.
  always_comb begin
    hit      = 1'b0;
    fwd_data = '0;
    slot     = '0;
    for (int k = 0; k < P_DEPTH; k++) begin
      slot = head_q + k[PW-1:0];
      if ((CW'(k) < count_q) && (addr_q[slot] == i_core_addr)) begin
        hit      = 1'b1;
        fwd_data = data_q[slot];
      end
    end
  end

`ifdef STORE_FWD_EN
  assign o_core_stall = 1'b0;
  assign drain        = nonempty & ~is_load;
  assign o_core_rdata = hit ? fwd_data : i_mem_rdata;
`else
  // A load that hits a pending store is held off and the cycle drains instead.
  logic unused_fwd;
  assign unused_fwd   = ^fwd_data;
  assign o_core_stall = is_load & hit;
  assign drain        = nonempty & (~is_load | hit);
  assign o_core_rdata = i_mem_rdata;
`endif

  assign push        = is_store & ((count_q != CW'(P_DEPTH)) | drain);
  assign o_mem_we    = drain;
  assign o_mem_addr  = drain ? addr_q[head_q] : i_core_addr;
  assign o_mem_wdata = data_q[head_q];
  assign o_empty     = ~nonempty;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    for (int k = 0; k < P_DEPTH; k++) begin
      addr_d[k] = addr_q[k];
      data_d[k] = data_q[k];
    end
    if (push) begin
      addr_d[tail_q] = i_core_addr;
      data_d[tail_q] = i_core_wdata;
      tail_d         = tail_q + PW'(1);
    end
    if (drain) begin
      head_d = head_q + PW'(1);
    end
    case ({push, drain})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry payload needs no reset; validity comes from head/count.
  always_ff @(posedge i_clk) begin
    for (int k = 0; k < P_DEPTH; k++) begin
      addr_q[k] <= addr_d[k];
      data_q[k] <= data_d[k];
    end
  end

endmodule

// File: tb/tb_dmem_store_buffer.sv
// Self-checking bench for dmem_store_buffer: vector table, write/load scoreboards, memory model.
module tb_dmem_store_buffer;
  localparam int DW = 32;
  localparam int AW = 11;
  localparam int DEPTH = 4;
  localparam int MSIZE = 1 << AW;

  logic          i_clk = 1'b0;
  logic          i_rst = 1'b1;
  logic          i_core_we = 1'b0, i_core_re = 1'b0;
  logic [AW-1:0] i_core_addr = '0;
  logic [DW-1:0] i_core_wdata = '0;
  logic [DW-1:0] o_core_rdata, o_mem_wdata, i_mem_rdata;
  logic          o_core_stall, o_mem_we, o_empty;
  logic [AW-1:0] o_mem_addr;

  dmem_store_buffer #(.P_DATA_WIDTH(DW), .P_DMEM_ADDR_WIDTH(AW), .P_DEPTH(DEPTH)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_core_we(i_core_we), .i_core_re(i_core_re),
    .i_core_addr(i_core_addr), .i_core_wdata(i_core_wdata), .o_core_rdata(o_core_rdata),
    .o_core_stall(o_core_stall), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
    .o_mem_wdata(o_mem_wdata), .i_mem_rdata(i_mem_rdata), .o_empty(o_empty)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;

  typedef struct {
    logic          we;
    logic          re;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] exp_rdata;
  } vec_t;

  logic [DW-1:0] mem        [MSIZE];
  logic [DW-1:0] ref_mem    [MSIZE];
  logic [DW-1:0] ref_commit [MSIZE];
  wr_t           wq[$];
  logic [DW-1:0] lq[$];
  vec_t          tbl[$];

  int n_checks = 0;
  int n_pass   = 0;

  assign i_mem_rdata = mem[o_mem_addr];

  function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
    return 32'hA5A5_0000 | DW'(a);
  endfunction

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Memory model plus write-order scoreboard: outputs sampled mid-cycle, applied at the edge.
  logic          mw_s = 1'b0;
  logic [AW-1:0] ma_s;
  logic [DW-1:0] md_s;
  always @(negedge i_clk) begin
    mw_s = o_mem_we;
    ma_s = o_mem_addr;
    md_s = o_mem_wdata;
  end
  always @(posedge i_clk) begin
    if (mw_s && !i_rst) begin
      wr_t e;
      mem[ma_s] = md_s;
      if (wq.size() == 0) begin
        chk("spurious_write", 32'(mw_s), 32'd0);
      end else begin
        e = wq.pop_front();
        chk("write_addr", DW'(ma_s), DW'(e.a));
        chk("write_data", md_s, e.d);
        ref_commit[e.a] = e.d;
      end
    end
    mw_s = 1'b0;
  end

  task automatic op(input logic we, input logic re, input logic [AW-1:0] a,
                    input logic [DW-1:0] d, input logic [DW-1:0] exp, output int stalls);
    logic ld;
    ld = re && !we;
    i_core_we = we; i_core_re = re; i_core_addr = a; i_core_wdata = d;
    if (ld) lq.push_back(exp);
    stalls = 0;
    forever begin
      @(negedge i_clk);
      chk("empty", 32'(o_empty), 32'(wq.size() == 0));
      if (ld && o_core_stall) begin
        stalls++;
`ifdef STORE_FWD_EN
        chk("fwd_no_stall", 32'(o_core_stall), 32'd0);
`endif
        if (stalls > DEPTH + 2) begin
          chk("stall_timeout", 32'(stalls), 32'(DEPTH + 2));
          void'(lq.pop_front());
          break;
        end
        @(posedge i_clk); #1;
        continue;
      end
      if (!ld) chk("store_idle_stall", 32'(o_core_stall), 32'd0);
      if (ld)  chk("load_data", o_core_rdata, lq.pop_front());
      break;
    end
    @(posedge i_clk);
    if (we) begin
      wr_t e;
      e.a = a; e.d = d;
      wq.push_back(e);
      ref_mem[a] = d;
    end
    #1;
    i_core_we = 1'b0; i_core_re = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  initial begin
    int s;
    for (int i = 0; i < MSIZE; i++) begin
      mem[i]        = init_val(AW'(i));
      ref_mem[i]    = init_val(AW'(i));
      ref_commit[i] = init_val(AW'(i));
    end

    // Forwarding / stall-on-hit pair, wrap-around stream, repeated loads of pending data.
    tbl.push_back('{1'b1, 1'b0, 11'h020, 32'h1, 32'h0});
    tbl.push_back('{1'b1, 1'b0, 11'h020, 32'h2, 32'h0});
    tbl.push_back('{1'b0, 1'b1, 11'h020, 32'h0, 32'h2});
    for (int i = 0; i < 10; i++) begin
      tbl.push_back('{1'b1, 1'b0, 11'h040 + AW'(i), 32'h1000 + DW'(i), 32'h0});
      tbl.push_back('{1'b0, 1'b1, 11'h040 + AW'(i), 32'h0, 32'h1000 + DW'(i)});
    end
    for (int i = 0; i < 4; i++)
      tbl.push_back('{1'b1, 1'b0, 11'h050 + AW'(i), 32'h5000 + DW'(i), 32'h0});
    for (int i = 0; i < 4; i++)
      tbl.push_back('{1'b0, 1'b1, 11'h050 + AW'(i), 32'h0, 32'h5000 + DW'(i)});
    tbl.push_back('{1'b1, 1'b1, 11'h054, 32'h5004, 32'h0});
    tbl.push_back('{1'b0, 1'b1, 11'h054, 32'h0, 32'h5004});
    tbl.push_back('{1'b0, 1'b1, 11'h055, 32'h0, 32'hA5A5_0055});

    #2;
    chk("reset_empty", 32'(o_empty), 32'd1);
    chk("reset_stall", 32'(o_core_stall), 32'd0);
    chk("reset_mem_we", 32'(o_mem_we), 32'd0);
    @(posedge i_clk); #1;
    i_rst = 1'b0;

    // Drain order
    op(1'b1, 1'b0, 11'h010, 32'hA, 32'h0, s);
    op(1'b1, 1'b0, 11'h011, 32'hB, 32'h0, s);
    @(negedge i_clk);
    chk("drain_we", 32'(o_mem_we), 32'd1);
    chk("drain_addr", DW'(o_mem_addr), 32'h11);
    chk("drain_data", o_mem_wdata, 32'hB);
    @(posedge i_clk); #1;
    @(negedge i_clk);
    chk("drain_empty", 32'(o_empty), 32'd1);
    chk("drain_mem10", mem[11'h010], 32'hA);
    chk("drain_mem11", mem[11'h011], 32'hB);
    @(posedge i_clk); #1;

    for (int i = 0; i < tbl.size(); i++)
      op(tbl[i].we, tbl[i].re, tbl[i].addr, tbl[i].wdata, tbl[i].exp_rdata, s);

    // Load right after a store to the same address
    op(1'b0, 1'b0, 11'h000, 32'h0, 32'h0, s);
    op(1'b1, 1'b0, 11'h030, 32'h5, 32'h0, s);
    op(1'b0, 1'b1, 11'h030, 32'h0, 32'h5, s);
`ifdef STORE_FWD_EN
    chk("hit_stall_cycles", 32'(s), 32'd0);
`else
    chk("hit_stall_cycles", 32'(s), 32'd1);
`endif

    // Reset with a store still pending discards it
    op(1'b1, 1'b0, 11'h060, 32'hDEAD_0060, 32'h0, s);
    i_core_re = 1'b1; i_core_addr = 11'h061; i_rst = 1'b1;
    wq.delete();
    for (int i = 0; i < MSIZE; i++) ref_mem[i] = ref_commit[i];
    #1;
    chk("midrst_empty", 32'(o_empty), 32'd1);
    chk("midrst_mem_we", 32'(o_mem_we), 32'd0);
    chk("midrst_stall", 32'(o_core_stall), 32'd0);
    @(posedge i_clk); #1;
    i_rst = 1'b0; i_core_re = 1'b0;
    op(1'b0, 1'b1, 11'h060, 32'h0, 32'hA5A5_0060, s);
    op(1'b0, 1'b1, 11'h020, 32'h0, 32'h2, s);

    // Random mix over a small address window, expectations from the program-order model
    for (int i = 0; i < 60; i++) begin
      logic [AW-1:0] a;
      logic          w, r;
      a = 11'h070 + AW'($urandom_range(0, 3));
      w = ($urandom_range(0, 2) == 0);
      r = ($urandom_range(0, 1) == 0);
      op(w, r, a, $urandom, ref_mem[a], s);
    end

    for (int i = 0; i < 4; i++) op(1'b0, 1'b0, 11'h000, 32'h0, 32'h0, s);
    chk("final_empty", 32'(o_empty), 32'd1);
    chk("final_wq", 32'(wq.size()), 32'd0);
    for (int i = 0; i < 128; i++) chk("final_mem", mem[i], ref_mem[i]);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
